bldc_startup_sequencer: RTL and testbench
=========================================

Name: bldc_startup_sequencer

Overview:
Sensor-to-sensorless startup and supervision controller for the BLDC drive. It sequences the PWM generator, the commutator and its Hall input through rotor alignment, an open-loop frequency/duty ramp, Hall lock-in, and closed-loop run. It drives the commutator's enable, use_hall, direction and open_loop_step_duration inputs and the common PWM duty. It supervises Hall validity and stall, and latches a fault code.

Parameters:
ALIGN_TIME_CLK, 32'd100000, cycles spent in rotor alignment
ALIGN_DUTY, 16'd200, duty applied during alignment
OL_START_STEP, 32'd500000, first open-loop step duration (clk)
OL_END_STEP, 32'd100000, final open-loop step duration; must be < OL_START_STEP
OL_STEP_DEC, 32'd20000, step-duration decrement per commutation step
DUTY_INC, 16'd10, duty slew increment per slew event
DUTY_SLEW_CLK, 16'd1000, cycles between duty slew events in RUN
HALL_LOCK_COUNT, 8'd6, consecutive in-order Hall edges required for handover
STALL_TIMEOUT_CLK, 32'd2000000, maximum cycles without a valid Hall edge (HANDOVER/RUN)

Ports:
clk  in  1  main clock
reset_n  in  1  asynchronous active-low reset
start  in  1  level; begins startup when sampled high in IDLE
stop  in  1  level; aborts/clears to IDLE
target_duty  in  16  run duty request
direction_req  in  1  0 forward, 1 reverse; sampled on leaving IDLE
hall_sensors  in  3  raw Hall code (async)
pwm_enable  out  1  PWM generator enable
bldc_enable  out  1  commutator enable
bldc_use_hall  out  1  commutator closed-loop select
bldc_direction  out  1  latched direction
open_loop_step_duration  out  32  commutator open-loop step length
duty  out  16  duty to all three PWM phases
state  out  3  current FSM state encoding
running  out  1  high only in RUN
fault  out  1  high only in FAULT
fault_code  out  2  0 none, 1 invalid Hall, 2 lock fail, 3 stall

Behaviour:
- Reset (async, reset_n low): state IDLE. All 1-bit outputs 0; duty 0; open_loop_step_duration 0; fault_code 0; all counters 0.
- hall_sensors passes through a 2-FF synchronizer. An edge is a change of the synchronized value versus the previous cycle, so edge detection lags the pin by 3 cycles.
- Forward sequence: 001->011->010->110->100->101->001. Reverse is the same cycle traversed backwards. 000 and 111 are invalid codes.
- Encodings: IDLE=0, ALIGN=1, RAMP=2, HANDOVER=3, RUN=4, FAULT=5. All outputs are registered.
- IDLE: all enables 0, duty 0. If start=1 and stop=0 → ALIGN. On that transition, latch bldc_direction=direction_req.
- ALIGN: pwm_enable=1, bldc_enable=1, use_hall=0. open_loop_step_duration=32'hFFFF_FFFF (holds the commutator on step 0). duty=ALIGN_DUTY. After ALIGN_TIME_CLK cycles → RAMP with step_duration=OL_START_STEP.
- RAMP: an internal step counter counts to open_loop_step_duration-1. At each wrap:
  - step_duration = max(step_duration−OL_STEP_DEC, OL_END_STEP).
  - duty = min(duty+DUTY_INC, target_duty).
  - On the wrap where step_duration becomes OL_END_STEP → HANDOVER.
- HANDOVER: open-loop continues at OL_END_STEP; duty keeps ramping per step.
  - Each in-order Hall edge increments lock_cnt and resets the stall timer.
  - An out-of-order edge clears lock_cnt to 0.
  - lock_cnt==HALL_LOCK_COUNT → RUN; use_hall=1 from the next cycle.
  - STALL_TIMEOUT_CLK cycles without an in-order edge → FAULT, code 2.
- RUN: use_hall=1. Every DUTY_SLEW_CLK cycles, duty moves toward target_duty by up to DUTY_INC, in either direction, with no overshoot.
  - An out-of-order edge → FAULT, code 3.
  - STALL_TIMEOUT_CLK cycles without a valid edge → FAULT, code 3.
- Invalid code (000/111, synchronized) in HANDOVER or RUN → FAULT, code 1 on the next cycle.
- FAULT: enables 0, duty 0, use_hall 0, fault=1, fault_code held. start is ignored. stop=1 → IDLE and fault_code cleared.
- stop=1 in ALIGN/RAMP/HANDOVER/RUN → IDLE next cycle. Stop has priority over any same-cycle fault or state advance.
- Changes to direction_req outside IDLE are ignored. target_duty changes are honoured only through slewing/saturation.
- Timers and the step counter clear on every state entry.

Decomposition:
- Shared package bldc_pkg holds:
  - state encodings
  - fault code constants
  - the Hall forward-next function (code → expected next code; reverse uses the inverse)
  - the INVALID code constants
- One natural sub-module: hall_edge_validator. It contains the synchronizer, edge detect and in-order/out-of-order/invalid classification, with direction as an input.

Test Plan:
- Sim parameters: ALIGN_TIME_CLK=100, OL_START_STEP=1000, OL_END_STEP=400, OL_STEP_DEC=200, DUTY_INC=50, HALL_LOCK_COUNT=6, STALL_TIMEOUT_CLK=5000.
- 1. Reset then start=1, target_duty=500: ALIGN for exactly 100 cycles with duty=200 and step=FFFFFFFF; RAMP steps 1000→800→600→400; duty 250,300,350; HANDOVER entered on the step-400 wrap.
- 2. From HANDOVER, hall simulator forward at 400 clk/step: RUN 1 cycle after the 6th in-order edge; use_hall=1; running=1; duty slews to 500.
- 3. In HANDOVER, inject an out-of-order edge after 4 good edges: lock_cnt resets; RUN requires 6 further good edges.
- 4. In RUN, force hall_sensors=3'b111: fault=1, fault_code=1, all enables 0 within 4 cycles. stop=1 → IDLE, fault_code=0.
- 5. In RUN, freeze the Hall inputs: FAULT with code 3 exactly 5000 cycles after the last valid edge. Separately, HANDOVER with no Halls: FAULT with code 2.
- 6. direction_req=1, reverse Hall sequence: lock and RUN with bldc_direction=1. Assert stop mid-RAMP together with a same-cycle stall: IDLE, no fault.

Source files
------------

// File: rtl/bldc_startup_sequencer_pkg.sv
// Shared definitions for the BLDC startup sequencer: state and fault encodings
// and the Hall commutation order.
package bldc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ALIGN    = 3'd1,
    ST_RAMP     = 3'd2,
    ST_HANDOVER = 3'd3,
    ST_RUN      = 3'd4,
    ST_FAULT    = 3'd5
  } state_t;

  localparam logic [1:0] FC_NONE    = 2'd0;
  localparam logic [1:0] FC_INVALID = 2'd1;
  localparam logic [1:0] FC_LOCK    = 2'd2;
  localparam logic [1:0] FC_STALL   = 2'd3;

  localparam logic [2:0] HALL_INV_LO = 3'b000;
  localparam logic [2:0] HALL_INV_HI = 3'b111;

  // Forward order 001->011->010->110->100->101->001; invalid codes map to 000.
  function automatic logic [2:0] hall_fwd_next(input logic [2:0] code);
    case (code)
      3'b001:  hall_fwd_next = 3'b011;
      3'b011:  hall_fwd_next = 3'b010;
      3'b010:  hall_fwd_next = 3'b110;
      3'b110:  hall_fwd_next = 3'b100;
      3'b100:  hall_fwd_next = 3'b101;
      3'b101:  hall_fwd_next = 3'b001;
      default: hall_fwd_next = HALL_INV_LO;
    endcase
  endfunction

  function automatic logic [2:0] hall_rev_next(input logic [2:0] code);
    case (code)
      3'b001:  hall_rev_next = 3'b101;
      3'b101:  hall_rev_next = 3'b100;
      3'b100:  hall_rev_next = 3'b110;
      3'b110:  hall_rev_next = 3'b010;
      3'b010:  hall_rev_next = 3'b011;
      3'b011:  hall_rev_next = 3'b001;
      default: hall_rev_next = HALL_INV_LO;
    endcase
  endfunction

endpackage

// File: rtl/bldc_startup_sequencer_if.sv
// Control/status bundle between the startup sequencer and its host/commutator.
interface bldc_startup_sequencer_if;
  logic        start;
  logic        stop;
  logic [15:0] target_duty;
  logic        direction_req;
  logic [2:0]  hall_sensors;
  logic        pwm_enable;
  logic        bldc_enable;
  logic        bldc_use_hall;
  logic        bldc_direction;
  logic [31:0] open_loop_step_duration;
  logic [15:0] duty;
  logic [2:0]  state;
  logic        running;
  logic        fault;
  logic [1:0]  fault_code;

  modport master (
    output start, stop, target_duty, direction_req, hall_sensors,
    input  pwm_enable, bldc_enable, bldc_use_hall, bldc_direction,
           open_loop_step_duration, duty, state, running, fault, fault_code
  );

  modport slave (
    input  start, stop, target_duty, direction_req, hall_sensors,
    output pwm_enable, bldc_enable, bldc_use_hall, bldc_direction,
           open_loop_step_duration, duty, state, running, fault, fault_code
  );
endinterface

// File: rtl/bldc_startup_sequencer_hall_edge_validator.sv
// Synchronizes the raw Hall code and classifies each change as in-order,
// out-of-order or invalid relative to the latched rotation direction.
module hall_edge_validator
  import bldc_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [2:0] i_hall,
  input  logic       i_dir,
  output logic       o_in_order,
  output logic       o_out_of_order,
  output logic       o_invalid
);

  logic [2:0] r_sync1;
  logic [2:0] r_sync2;
  logic [2:0] r_prev;
  logic [2:0] w_expected;
  logic       w_edge;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= i_hall;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
    end
  end

  assign w_edge         = (r_sync2 != r_prev);
  assign w_expected     = i_dir ? hall_rev_next(r_prev) : hall_fwd_next(r_prev);
  assign o_invalid      = (r_sync2 == HALL_INV_LO) || (r_sync2 == HALL_INV_HI);
  assign o_in_order     = w_edge && !o_invalid && (r_sync2 == w_expected);
  assign o_out_of_order = w_edge && !o_invalid && (r_sync2 != w_expected);

endmodule

// File: rtl/bldc_startup_sequencer.sv
// BLDC startup sequencer: align, open-loop ramp, Hall lock-in, closed-loop run,
// with Hall/stall supervision and a latched fault code.
module bldc_startup_sequencer
  import bldc_pkg::*;
#(
  parameter logic [31:0] ALIGN_TIME_CLK    = 32'd100000,
  parameter logic [15:0] ALIGN_DUTY        = 16'd200,
  parameter logic [31:0] OL_START_STEP     = 32'd500000,
  parameter logic [31:0] OL_END_STEP       = 32'd100000,
  parameter logic [31:0] OL_STEP_DEC       = 32'd20000,
  parameter logic [15:0] DUTY_INC          = 16'd10,
  parameter logic [15:0] DUTY_SLEW_CLK     = 16'd1000,
  parameter logic [7:0]  HALL_LOCK_COUNT   = 8'd6,
  parameter logic [31:0] STALL_TIMEOUT_CLK = 32'd2000000
) (
  input  logic clk,
  input  logic reset_n,
  bldc_startup_sequencer_if.slave bus
);

  state_t      r_state, w_state_nxt;
  logic [31:0] r_tmr, w_tmr_nxt;
  logic [31:0] r_stall, w_stall_nxt;
  logic [31:0] r_step, w_step_nxt;
  logic [15:0] r_slew, w_slew_nxt;
  logic [15:0] r_duty, w_duty_nxt;
  logic [7:0]  r_lock, w_lock_nxt;
  logic [1:0]  r_fcode, w_fcode_nxt;
  logic        r_dir, w_dir_nxt;
  logic        r_pwm_en, r_bldc_en, r_use_hall, r_running, r_fault;
  logic        w_in_order, w_out_of_order, w_invalid;
  logic [16:0] w_duty_sum;
  logic [15:0] w_duty_ramp, w_duty_slew;
  logic [31:0] w_step_dec;

  hall_edge_validator u_hall (
    .clk            (clk),
    .reset_n        (reset_n),
    .i_hall         (bus.hall_sensors),
    .i_dir          (r_dir),
    .o_in_order     (w_in_order),
    .o_out_of_order (w_out_of_order),
    .o_invalid      (w_invalid)
  );

  assign w_duty_sum  = {1'b0, r_duty} + {1'b0, DUTY_INC};
  assign w_duty_ramp = (w_duty_sum > {1'b0, bus.target_duty}) ? bus.target_duty : w_duty_sum[15:0];
  assign w_duty_slew = (r_duty < bus.target_duty) ? w_duty_ramp :
                       ((r_duty - bus.target_duty) > DUTY_INC) ? (r_duty - DUTY_INC) : bus.target_duty;
  assign w_step_dec  = (r_step >= OL_END_STEP + OL_STEP_DEC) ? (r_step - OL_STEP_DEC) : OL_END_STEP;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= ST_IDLE;
      r_tmr      <= '0;
      r_stall    <= '0;
      r_step     <= '0;
      r_slew     <= '0;
      r_duty     <= '0;
      r_lock     <= '0;
      r_fcode    <= FC_NONE;
      r_dir      <= 1'b0;
      r_pwm_en   <= 1'b0;
      r_bldc_en  <= 1'b0;
      r_use_hall <= 1'b0;
      r_running  <= 1'b0;
      r_fault    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tmr      <= w_tmr_nxt;
      r_stall    <= w_stall_nxt;
      r_step     <= w_step_nxt;
      r_slew     <= w_slew_nxt;
      r_duty     <= w_duty_nxt;
      r_lock     <= w_lock_nxt;
      r_fcode    <= w_fcode_nxt;
      r_dir      <= w_dir_nxt;
      r_pwm_en   <= w_state_nxt inside {ST_ALIGN, ST_RAMP, ST_HANDOVER, ST_RUN};
      r_bldc_en  <= w_state_nxt inside {ST_ALIGN, ST_RAMP, ST_HANDOVER, ST_RUN};
      r_use_hall <= (w_state_nxt == ST_RUN);
      r_running  <= (w_state_nxt == ST_RUN);
      r_fault    <= (w_state_nxt == ST_FAULT);
    end
  end

  // Timers are down-counters loaded on state entry; terminal count is zero.
  always_comb begin
    w_state_nxt = r_state;
    w_tmr_nxt   = r_tmr;
    w_stall_nxt = r_stall;
    w_step_nxt  = r_step;
    w_slew_nxt  = r_slew;
    w_duty_nxt  = r_duty;
    w_lock_nxt  = r_lock;
    w_fcode_nxt = r_fcode;
    w_dir_nxt   = r_dir;

    case (r_state)
      ST_IDLE: begin
        if (bus.start && !bus.stop) begin
          w_state_nxt = ST_ALIGN;
          w_dir_nxt   = bus.direction_req;
          w_duty_nxt  = ALIGN_DUTY;
          w_step_nxt  = 32'hFFFF_FFFF;
          w_tmr_nxt   = ALIGN_TIME_CLK - 32'd1;
        end
      end
      ST_ALIGN: begin
        if (r_tmr == '0) begin
          w_state_nxt = ST_RAMP;
          w_step_nxt  = OL_START_STEP;
          w_tmr_nxt   = OL_START_STEP - 32'd1;
        end else begin
          w_tmr_nxt = r_tmr - 32'd1;
        end
      end
      ST_RAMP: begin
        if (r_tmr == '0) begin
          w_step_nxt = w_step_dec;
          w_duty_nxt = w_duty_ramp;
          w_tmr_nxt  = w_step_dec - 32'd1;
          if (w_step_dec == OL_END_STEP) begin
            w_state_nxt = ST_HANDOVER;
            w_stall_nxt = STALL_TIMEOUT_CLK - 32'd1;
            w_lock_nxt  = '0;
          end
        end else begin
          w_tmr_nxt = r_tmr - 32'd1;
        end
      end
      ST_HANDOVER: begin
        if (r_tmr == '0) begin
          w_duty_nxt = w_duty_ramp;
          w_tmr_nxt  = OL_END_STEP - 32'd1;
        end else begin
          w_tmr_nxt = r_tmr - 32'd1;
        end
        // An out-of-order edge restarts the lock count but not the stall timer.
        if (w_in_order) begin
          w_lock_nxt  = r_lock + 8'd1;
          w_stall_nxt = STALL_TIMEOUT_CLK - 32'd1;
        end else begin
          if (w_out_of_order) w_lock_nxt = '0;
          if (r_stall == '0) begin
            w_state_nxt = ST_FAULT;
            w_fcode_nxt = FC_LOCK;
          end else begin
            w_stall_nxt = r_stall - 32'd1;
          end
        end
        if (r_lock == HALL_LOCK_COUNT) begin
          w_state_nxt = ST_RUN;
          w_fcode_nxt = r_fcode;
          w_tmr_nxt   = '0;
          w_lock_nxt  = '0;
          w_stall_nxt = STALL_TIMEOUT_CLK - 32'd1;
          w_slew_nxt  = DUTY_SLEW_CLK - 16'd1;
        end
        if (w_invalid) begin
          w_state_nxt = ST_FAULT;
          w_fcode_nxt = FC_INVALID;
        end
      end
      ST_RUN: begin
        if (r_slew == '0) begin
          w_duty_nxt = w_duty_slew;
          w_slew_nxt = DUTY_SLEW_CLK - 16'd1;
        end else begin
          w_slew_nxt = r_slew - 16'd1;
        end
        if (w_in_order) begin
          w_stall_nxt = STALL_TIMEOUT_CLK - 32'd1;
        end else if (w_out_of_order || (r_stall == '0)) begin
          w_state_nxt = ST_FAULT;
          w_fcode_nxt = FC_STALL;
        end else begin
          w_stall_nxt = r_stall - 32'd1;
        end
        if (w_invalid) begin
          w_state_nxt = ST_FAULT;
          w_fcode_nxt = FC_INVALID;
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase

    if (bus.stop) begin
      w_state_nxt = ST_IDLE;
      w_fcode_nxt = FC_NONE;
    end

    if ((w_state_nxt == ST_IDLE) || (w_state_nxt == ST_FAULT)) begin
      w_tmr_nxt   = '0;
      w_stall_nxt = '0;
      w_slew_nxt  = '0;
      w_lock_nxt  = '0;
      w_step_nxt  = '0;
      w_duty_nxt  = '0;
    end
  end

  assign bus.pwm_enable              = r_pwm_en;
  assign bus.bldc_enable             = r_bldc_en;
  assign bus.bldc_use_hall           = r_use_hall;
  assign bus.bldc_direction          = r_dir;
  assign bus.open_loop_step_duration = r_step;
  assign bus.duty                    = r_duty;
  assign bus.state                   = r_state;
  assign bus.running                 = r_running;
  assign bus.fault                   = r_fault;
  assign bus.fault_code              = r_fcode;

endmodule

// File: tb/tb_bldc_startup_sequencer.sv
// Directed bench for bldc_startup_sequencer with shortened timing parameters.
module tb_bldc_startup_sequencer;

  logic clk;
  logic reset_n;
  int   n_cmp;
  int   n_bad;

  bldc_startup_sequencer_if bus();

  bldc_startup_sequencer #(
    .ALIGN_TIME_CLK    (32'd100),
    .ALIGN_DUTY        (16'd200),
    .OL_START_STEP     (32'd1000),
    .OL_END_STEP       (32'd400),
    .OL_STEP_DEC       (32'd200),
    .DUTY_INC          (16'd50),
    .DUTY_SLEW_CLK     (16'd1000),
    .HALL_LOCK_COUNT   (8'd6),
    .STALL_TIMEOUT_CLK (32'd5000)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        start;
    int          wait_cyc;
    logic [2:0]  st;
    logic [15:0] duty;
    logic [31:0] step;
    logic        pwm;
    logic        use_hall;
  } vec_t;

  vec_t       vecs [9];
  logic [2:0] hall_seq [6];
  int         hall_idx;
  logic       hall_dir;
  logic       hall_auto;
  int         hall_phase;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic hall_advance();
    hall_idx = hall_dir ? (hall_idx + 5) % 6 : (hall_idx + 1) % 6;
    bus.hall_sensors = hall_seq[hall_idx];
  endtask

  // Every tick lands 1 time unit after a rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (hall_auto) begin
        hall_phase++;
        if (hall_phase == 400) begin
          hall_phase = 0;
          hall_advance();
        end
      end
    end
  endtask

  // Start from IDLE and land on the first cycle of HANDOVER (2501 cycles later).
  task automatic startup(input logic dir);
    bus.direction_req = dir;
    bus.target_duty   = 16'd500;
    bus.start         = 1'b1;
    tick(1);
    chk("startup_align", 32'(bus.state), 32'd1);
    chk("startup_dir", 32'(bus.bldc_direction), 32'(dir));
    bus.start         = 1'b0;
    bus.direction_req = ~dir;
    tick(2500);
    chk("startup_handover", 32'(bus.state), 32'd3);
    chk("startup_dir_held", 32'(bus.bldc_direction), 32'(dir));
  endtask

  task automatic do_stop();
    bus.stop = 1'b1;
    tick(1);
    chk("stop_idle", 32'(bus.state), 32'd0);
    chk("stop_fault", 32'(bus.fault), 32'd0);
    chk("stop_code", 32'(bus.fault_code), 32'd0);
    bus.stop = 1'b0;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    hall_seq[0] = 3'b001; hall_seq[1] = 3'b011; hall_seq[2] = 3'b010;
    hall_seq[3] = 3'b110; hall_seq[4] = 3'b100; hall_seq[5] = 3'b101;
    hall_idx = 0; hall_dir = 1'b0; hall_auto = 1'b0; hall_phase = 0;

    // start, cycles to wait, state, duty, step, pwm_enable, use_hall
    vecs[0] = '{1'b1,   1, 3'd1, 16'd200, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[1] = '{1'b0,  99, 3'd1, 16'd200, 32'hFFFF_FFFF, 1'b1, 1'b0};
    vecs[2] = '{1'b0,   1, 3'd2, 16'd200, 32'd1000,      1'b1, 1'b0};
    vecs[3] = '{1'b0, 999, 3'd2, 16'd200, 32'd1000,      1'b1, 1'b0};
    vecs[4] = '{1'b0,   1, 3'd2, 16'd250, 32'd800,       1'b1, 1'b0};
    vecs[5] = '{1'b0, 799, 3'd2, 16'd250, 32'd800,       1'b1, 1'b0};
    vecs[6] = '{1'b0,   1, 3'd2, 16'd300, 32'd600,       1'b1, 1'b0};
    vecs[7] = '{1'b0, 599, 3'd2, 16'd300, 32'd600,       1'b1, 1'b0};
    vecs[8] = '{1'b0,   1, 3'd3, 16'd350, 32'd400,       1'b1, 1'b0};

    reset_n           = 1'b0;
    bus.start         = 1'b0;
    bus.stop          = 1'b0;
    bus.target_duty   = 16'd500;
    bus.direction_req = 1'b0;
    bus.hall_sensors  = hall_seq[0];
    tick(3);
    chk("rst_state", 32'(bus.state), 32'd0);
    chk("rst_duty", 32'(bus.duty), 32'd0);
    chk("rst_step", bus.open_loop_step_duration, 32'd0);
    chk("rst_pwm", 32'(bus.pwm_enable), 32'd0);
    chk("rst_code", 32'(bus.fault_code), 32'd0);
    reset_n = 1'b1;
    tick(5);

    // 1: align and ramp profile
    for (int i = 0; i < 9; i++) begin
      bus.start = vecs[i].start;
      tick(vecs[i].wait_cyc);
      chk($sformatf("vec%0d_state", i), 32'(bus.state), 32'(vecs[i].st));
      chk($sformatf("vec%0d_duty", i), 32'(bus.duty), 32'(vecs[i].duty));
      chk($sformatf("vec%0d_step", i), bus.open_loop_step_duration, vecs[i].step);
      chk($sformatf("vec%0d_pwm", i), 32'(bus.pwm_enable), 32'(vecs[i].pwm));
      chk($sformatf("vec%0d_bldc_en", i), 32'(bus.bldc_enable), 32'(vecs[i].pwm));
      chk($sformatf("vec%0d_use_hall", i), 32'(bus.bldc_use_hall), 32'(vecs[i].use_hall));
    end

    // 2: forward lock-in, RUN one cycle after the 6th edge is seen
    for (int i = 0; i < 5; i++) begin
      hall_advance();
      tick(400);
    end
    hall_advance();
    tick(3);
    chk("lock_pre_run", 32'(bus.state), 32'd3);
    tick(1);
    chk("lock_run", 32'(bus.state), 32'd4);
    chk("lock_use_hall", 32'(bus.bldc_use_hall), 32'd1);
    chk("lock_running", 32'(bus.running), 32'd1);
    chk("lock_duty", 32'(bus.duty), 32'd500);

    // RUN slewing down then up, no overshoot
    bus.target_duty = 16'd380;
    hall_phase = 0;
    hall_auto  = 1'b1;
    tick(999);
    chk("slew_hold", 32'(bus.duty), 32'd500);
    tick(1);
    chk("slew_dn1", 32'(bus.duty), 32'd450);
    tick(1000);
    chk("slew_dn2", 32'(bus.duty), 32'd400);
    tick(1000);
    chk("slew_dn3", 32'(bus.duty), 32'd380);
    bus.target_duty = 16'd450;
    tick(1000);
    chk("slew_up1", 32'(bus.duty), 32'd430);
    tick(1000);
    chk("slew_up2", 32'(bus.duty), 32'd450);
    chk("slew_running", 32'(bus.running), 32'd1);

    // 4: invalid Hall code in RUN
    hall_auto = 1'b0;
    bus.hall_sensors = 3'b111;
    tick(2);
    chk("inv_not_yet", 32'(bus.state), 32'd4);
    tick(1);
    chk("inv_state", 32'(bus.state), 32'd5);
    chk("inv_fault", 32'(bus.fault), 32'd1);
    chk("inv_code", 32'(bus.fault_code), 32'd1);
    chk("inv_pwm", 32'(bus.pwm_enable), 32'd0);
    chk("inv_bldc_en", 32'(bus.bldc_enable), 32'd0);
    chk("inv_use_hall", 32'(bus.bldc_use_hall), 32'd0);
    chk("inv_duty", 32'(bus.duty), 32'd0);
    bus.start = 1'b1;
    tick(5);
    chk("fault_ignores_start", 32'(bus.state), 32'd5);
    chk("fault_code_held", 32'(bus.fault_code), 32'd1);
    bus.start = 1'b0;
    do_stop();
    hall_idx = 0;
    bus.hall_sensors = hall_seq[0];
    tick(5);

    // 3: out-of-order edge after 4 good ones restarts the lock count
    startup(1'b0);
    for (int i = 0; i < 4; i++) begin
      hall_advance();
      tick(400);
    end
    hall_idx = 1;
    bus.hall_sensors = hall_seq[1];
    tick(400);
    chk("ooo_still_handover", 32'(bus.state), 32'd3);
    for (int i = 0; i < 5; i++) begin
      hall_advance();
      tick(400);
    end
    chk("ooo_five_more", 32'(bus.state), 32'd3);
    hall_advance();
    tick(3);
    chk("ooo_pre_run", 32'(bus.state), 32'd3);
    tick(1);
    chk("ooo_run", 32'(bus.state), 32'd4);

    // 5a: frozen Halls in RUN; edge lands 3 cycles after the pin, fault 5000 later
    tick(100);
    hall_advance();
    tick(5002);
    chk("stall_run_pre", 32'(bus.state), 32'd4);
    tick(1);
    chk("stall_run_state", 32'(bus.state), 32'd5);
    chk("stall_run_code", 32'(bus.fault_code), 32'd3);
    do_stop();

    // 5b: no Halls in HANDOVER
    startup(1'b0);
    tick(4999);
    chk("lockfail_pre", 32'(bus.state), 32'd3);
    tick(1);
    chk("lockfail_state", 32'(bus.state), 32'd5);
    chk("lockfail_code", 32'(bus.fault_code), 32'd2);
    do_stop();

    // 6a: reverse rotation lock-in
    hall_dir = 1'b1;
    startup(1'b1);
    for (int i = 0; i < 5; i++) begin
      hall_advance();
      tick(400);
    end
    hall_advance();
    tick(3);
    chk("rev_pre_run", 32'(bus.state), 32'd3);
    tick(1);
    chk("rev_run", 32'(bus.state), 32'd4);
    chk("rev_dir", 32'(bus.bldc_direction), 32'd1);
    do_stop();
    hall_dir = 1'b0;

    // 6b: stop on the very cycle the HANDOVER stall would fire
    startup(1'b0);
    tick(4999);
    chk("stopstall_pre", 32'(bus.state), 32'd3);
    do_stop();

    // stop mid-RAMP
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(1500);
    chk("ramp_mid", 32'(bus.state), 32'd2);
    do_stop();
    chk("ramp_stop_duty", 32'(bus.duty), 32'd0);
    chk("ramp_stop_pwm", 32'(bus.pwm_enable), 32'd0);

    // asynchronous reset between clock edges
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
    tick(50);
    chk("arst_pre", 32'(bus.state), 32'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(bus.state), 32'd0);
    chk("arst_pwm", 32'(bus.pwm_enable), 32'd0);
    chk("arst_duty", 32'(bus.duty), 32'd0);
    reset_n = 1'b1;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
